v_load_seq: RTL and testbench

Parametrised multi-beat vector load sequencer for the coprocessor's vector LSU. It accepts one load command (unit-stride or strided, SEW 8/16/32, LMUL 1/2/4, vl), issues LANES parallel 32-bit reads per beat and packs returned elements at SEW granularity into a register-group image. When the group is complete, it hands the image to the vector register file writeback in one pulse. It sits between the vector decode/issue stage and the data memory port, and replaces the single-beat combinational loader.

---
 rtl/v_pkg.sv | 51 +++++
 rtl/v_lsu_agen.sv | 25 ++
 rtl/v_load_seq.sv | 167 ++++++++++++++++
 tb/tb_v_load_seq.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/v_pkg.sv
// Shared opcodes, FSM states and decode helpers for the vector load sequencer.
// Opcode encodings must match the vector decode stage.
package v_pkg;

   localparam int VLEN = 128;

   localparam logic [3:0] VLSU_VLE8   = 4'd0;
   localparam logic [3:0] VLSU_VLE16  = 4'd1;
   localparam logic [3:0] VLSU_VLE32  = 4'd2;
   localparam logic [3:0] VLSU_VLSE8  = 4'd3;
   localparam logic [3:0] VLSU_VLSE16 = 4'd4;
   localparam logic [3:0] VLSU_VLSE32 = 4'd5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } state_e;

   // Unknown opcodes fall back to 32-bit elements.
   function automatic logic [5:0] sew_of(input logic [3:0] op);
      case (op)
         VLSU_VLE8,  VLSU_VLSE8:  sew_of = 6'd8;
         VLSU_VLE16, VLSU_VLSE16: sew_of = 6'd16;
         default:                 sew_of = 6'd32;
      endcase
   endfunction

   function automatic int sew_log2(input logic [5:0] sew);
      case (sew)
         6'd8:    sew_log2 = 3;
         6'd16:   sew_log2 = 4;
         default: sew_log2 = 5;
      endcase
   endfunction

   // Reserved LMUL encodings behave as a single register.
   function automatic logic [2:0] nreg_of(input logic [2:0] lmul);
      case (lmul)
         3'b001:  nreg_of = 3'd2;
         3'b010:  nreg_of = 3'd4;
         default: nreg_of = 3'd1;
      endcase
   endfunction

   function automatic logic is_strided(input logic [3:0] op);
      is_strided = (op == VLSU_VLSE8) || (op == VLSU_VLSE16) || (op == VLSU_VLSE32);
   endfunction

endpackage

// File: rtl/v_lsu_agen.sv
// Per-lane address and enable generation for one beat of a vector load.
// Purely combinational; the caller gates the outputs onto the memory port.
module v_lsu_agen #(
   parameter int LANES = 4,
   parameter int VLW   = 7
) (
   input  logic [31:0]          cur_addr,
   input  logic [31:0]          step,
   input  logic [VLW-1:0]       beat,
   input  logic [VLW-1:0]       elems,
   output logic [LANES*32-1:0]  lane_addr,
   output logic [LANES-1:0]     lane_en
);

   always_comb begin
      lane_addr = '0;
      lane_en   = '0;
      for (int i = 0; i < LANES; i++) begin
         // Lane i of beat b carries element b*LANES+i; addresses wrap at 2^32.
         lane_addr[32*i +: 32] = cur_addr + 32'(i) * step;
         lane_en[i]            = (int'(beat) * LANES + i) < int'(elems);
      end
   end

endmodule

// File: rtl/v_load_seq.sv
// Multi-beat vector load sequencer: issues LANES reads per beat and packs the
// returned elements at SEW granularity into a register-group writeback image.
module v_load_seq #(
   parameter int VLEN     = v_pkg::VLEN,
   parameter int LANES    = 4,
   parameter int MAX_LMUL = 4,
   parameter int VLW      = 7
) (
   input  logic                       clk,
   input  logic                       nrst,
   input  logic                       start,
   input  logic [3:0]                 vlsu_op,
   input  logic [2:0]                 lmul,
   input  logic [VLW-1:0]             vl,
   input  logic [31:0]                base_addr,
   input  logic [31:0]                stride,
   output logic                       busy,
   output logic                       mem_req,
   output logic [LANES*32-1:0]        mem_addr,
   output logic [LANES-1:0]           mem_lane_en,
   input  logic                       mem_gnt,
   input  logic                       mem_rvalid,
   input  logic [LANES*32-1:0]        mem_rdata,
   output logic                       wb_valid,
   output logic [VLEN*MAX_LMUL-1:0]   wb_data,
   output logic [2:0]                 wb_nreg
);

   import v_pkg::*;

   localparam int GW = VLEN * MAX_LMUL;
   localparam int LW = $clog2(LANES);
   localparam logic [VLW-1:0] ONE = VLW'(1);

   state_e              state;
   logic [5:0]          sew_q;
   logic [VLW-1:0]      elems_q;
   logic [VLW-1:0]      beats_q;
   logic [VLW-1:0]      beat_q;
   logic [31:0]         step_q;
   logic [31:0]         cur_addr;

   logic [5:0]          sew_in;
   logic [2:0]          nreg_in;
   logic [VLW-1:0]      cap_in;
   logic [VLW-1:0]      elems_in;
   logic [VLW-1:0]      beats_in;
   logic [31:0]         step_in;
   logic                last_beat;

   logic [LANES*32-1:0] lane_addr;
   logic [LANES-1:0]    lane_en;
   logic [GW-1:0]       wb_pack;

   // Command decode, used only on the accepting cycle.
   always_comb begin
      sew_in   = sew_of(vlsu_op);
      nreg_in  = nreg_of(lmul);
      cap_in   = VLW'((VLEN * int'(nreg_in)) >> sew_log2(sew_in));
      elems_in = (vl < cap_in) ? vl : cap_in;
      beats_in = VLW'((int'(elems_in) + LANES - 1) >> LW);
      step_in  = is_strided(vlsu_op) ? stride : {29'b0, sew_in[5:3]};
   end

   assign last_beat = (beat_q == beats_q - ONE);

   v_lsu_agen #(
      .LANES (LANES),
      .VLW   (VLW)
   ) u_agen (
      .cur_addr  (cur_addr),
      .step      (step_q),
      .beat      (beat_q),
      .elems     (elems_q),
      .lane_addr (lane_addr),
      .lane_en   (lane_en)
   );

   // Address bus is only driven while a request is outstanding, so it stays
   // frozen through grant stalls and reads as zero otherwise.
   assign mem_addr    = mem_req ? lane_addr : '0;
   assign mem_lane_en = mem_req ? lane_en   : '0;

   always_comb begin
      wb_pack = wb_data;
      for (int i = 0; i < LANES; i++) begin
         if (lane_en[i]) begin
            case (sew_q)
               6'd8:    wb_pack[(int'(beat_q) * LANES + i) * 8  +: 8]  = mem_rdata[32*i +: 8];
               6'd16:   wb_pack[(int'(beat_q) * LANES + i) * 16 +: 16] = mem_rdata[32*i +: 16];
               default: wb_pack[(int'(beat_q) * LANES + i) * 32 +: 32] = mem_rdata[32*i +: 32];
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state    <= IDLE;
         busy     <= 1'b0;
         mem_req  <= 1'b0;
         wb_valid <= 1'b0;
         wb_data  <= '0;
         wb_nreg  <= '0;
         sew_q    <= '0;
         elems_q  <= '0;
         beats_q  <= '0;
         beat_q   <= '0;
         step_q   <= '0;
         cur_addr <= '0;
      end else begin
         wb_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  busy     <= 1'b1;
                  sew_q    <= sew_in;
                  elems_q  <= elems_in;
                  beats_q  <= beats_in;
                  beat_q   <= '0;
                  step_q   <= step_in;
                  cur_addr <= base_addr;
                  wb_data  <= '0;
                  wb_nreg  <= nreg_in;
                  if (beats_in == '0) begin
                     state    <= DONE;
                     wb_valid <= 1'b1;
                  end else begin
                     state   <= REQ;
                     mem_req <= 1'b1;
                  end
               end
            end
            REQ: begin
               if (mem_gnt) begin
                  mem_req <= 1'b0;
                  state   <= WAIT;
               end
            end
            WAIT: begin
               if (mem_rvalid) begin
                  wb_data  <= wb_pack;
                  beat_q   <= beat_q + ONE;
                  cur_addr <= cur_addr + (step_q << LW);
                  if (last_beat) begin
                     state    <= DONE;
                     wb_valid <= 1'b1;
                  end else begin
                     state   <= REQ;
                     mem_req <= 1'b1;
                  end
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state   <= IDLE;
               busy    <= 1'b0;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_v_load_seq.sv
// Bench for v_load_seq: directed commands, a responding memory model with
// configurable grant/rvalid delays, and a scoreboard on the writeback pulse.
module tb_v_load_seq;
   import v_pkg::*;

   logic          clk;
   logic          nrst;
   logic          start;
   logic [3:0]    vlsu_op;
   logic [2:0]    lmul;
   logic [6:0]    vl;
   logic [31:0]   base_addr;
   logic [31:0]   stride;
   logic          busy;
   logic          mem_req;
   logic [127:0]  mem_addr;
   logic [3:0]    mem_lane_en;
   logic          mem_gnt;
   logic          mem_rvalid;
   logic [127:0]  mem_rdata;
   logic          wb_valid;
   logic [511:0]  wb_data;
   logic [2:0]    wb_nreg;

   v_load_seq #(.VLEN(128), .LANES(4), .MAX_LMUL(4), .VLW(7)) dut (
      .clk         (clk),
      .nrst        (nrst),
      .start       (start),
      .vlsu_op     (vlsu_op),
      .lmul        (lmul),
      .vl          (vl),
      .base_addr   (base_addr),
      .stride      (stride),
      .busy        (busy),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_lane_en (mem_lane_en),
      .mem_gnt     (mem_gnt),
      .mem_rvalid  (mem_rvalid),
      .mem_rdata   (mem_rdata),
      .wb_valid    (wb_valid),
      .wb_data     (wb_data),
      .wb_nreg     (wb_nreg)
   );

   typedef struct {
      logic [511:0] data;
      logic [2:0]   nreg;
      int           lat;
      int           t0;
   } exp_t;

   exp_t          sb[$];
   int            checks = 0;
   int            failures = 0;
   int            cyc = 0;

   int            dmode = 0;
   int            gnt_delay = 0;
   int            rv_delay = 0;
   int            mb = 0;
   int            stall_seen = 0;
   bit            stall_bad = 0;
   logic [127:0]  got_addr [16];
   logic [3:0]    got_en [16];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   function automatic logic [31:0] gen_word(input int k);
      if (dmode == 0) gen_word = 32'h11 * 32'(k + 1);
      else            gen_word = 32'hEEDD_A000 | 32'(k);
   endfunction

   // Memory model: drives gnt/rvalid on the falling edge.
   initial begin
      int          stall;
      int          rv_wait;
      int          rb;
      bit          pending;
      bit          busy_prev;
      logic [131:0] snap;
      stall = 0; rv_wait = 0; rb = 0; pending = 0; busy_prev = 0; snap = '0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = {4{32'hDEADBEEF}};
      forever begin
         @(negedge clk);
         mem_gnt    = 1'b0;
         mem_rvalid = 1'b0;
         mem_rdata  = {4{32'hDEADBEEF}};
         if (!nrst) begin
            pending = 0;
            stall   = 0;
         end else begin
            if (busy && !busy_prev) begin
               mb = 0; stall_seen = 0; stall_bad = 0;
            end
            if (pending) begin
               if (rv_wait > 0) rv_wait--;
               else begin
                  mem_rvalid = 1'b1;
                  for (int i = 0; i < 4; i++) mem_rdata[32*i +: 32] = gen_word(rb * 4 + i);
                  pending = 0;
               end
            end else if (mem_req) begin
               if (stall == 0) snap = {mem_addr, mem_lane_en};
               else if ({mem_addr, mem_lane_en} !== snap) stall_bad = 1;
               if (stall < gnt_delay) begin
                  stall++;
                  stall_seen++;
               end else begin
                  mem_gnt = 1'b1;
                  stall   = 0;
                  if (mb < 16) begin
                     got_addr[mb] = mem_addr;
                     got_en[mb]   = mem_lane_en;
                  end
                  rb      = mb;
                  mb++;
                  pending = 1;
                  rv_wait = rv_delay;
               end
            end
         end
         busy_prev = busy;
      end
   end

   // Monitor: every writeback pulse must match the oldest queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (wb_valid) begin
            if (sb.size() == 0) chk("wb_unexpected", 512'(wb_valid), 512'd0);
            else begin
               e = sb.pop_front();
               chk("wb_data", wb_data, e.data);
               chk("wb_nreg", 512'(wb_nreg), 512'(e.nreg));
               chk("wb_latency", 512'(cyc - e.t0), 512'(e.lat));
            end
         end
      end
   end

   task automatic run_cmd(input logic [3:0] op, input logic [2:0] lm, input logic [6:0] v,
                          input logic [31:0] base, input logic [31:0] str,
                          input logic [511:0] ed, input logic [2:0] en, input int lat,
                          input logic ereq, input bit poke);
      exp_t e;
      int   n;
      @(negedge clk);
      vlsu_op = op; lmul = lm; vl = v; base_addr = base; stride = str; start = 1'b1;
      e.data = ed; e.nreg = en; e.lat = lat; e.t0 = cyc;
      sb.push_back(e);
      @(posedge clk);
      #1;
      chk("busy_after_start", 512'(busy), 512'd1);
      chk("mem_req_after_start", 512'(mem_req), 512'(ereq));
      start = 1'b0;
      vlsu_op = VLSU_VLSE8; lmul = 3'b010; vl = 7'h7F; base_addr = 32'hCAFE0000; stride = 32'h0FF0;
      if (poke) begin
         repeat (2) @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(posedge clk);
         n++;
      end
      #2;
      chk("wb_timeout", 512'(sb.size()), 512'd0);
      sb.delete();
      repeat (6) @(negedge clk);
      chk("busy_after_done", 512'(busy), 512'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [511:0] e;
      int n;
      nrst = 1'b0; start = 1'b0; vlsu_op = '0; lmul = '0; vl = '0; base_addr = '0; stride = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 512'(busy), 512'd0);
      chk("rst_mem_req", 512'(mem_req), 512'd0);
      chk("rst_mem_addr", 512'(mem_addr), 512'd0);
      chk("rst_lane_en", 512'(mem_lane_en), 512'd0);
      chk("rst_wb_valid", 512'(wb_valid), 512'd0);
      chk("rst_wb_data", wb_data, 512'd0);
      chk("rst_wb_nreg", 512'(wb_nreg), 512'd0);
      nrst = 1'b1;
      repeat (2) @(negedge clk);

      // Unit-stride 32-bit, single beat.
      dmode = 0;
      e = '0; e[127:0] = 128'h00000044_00000033_00000022_00000011;
      run_cmd(VLSU_VLE32, 3'b000, 7'd4, 32'h100, 32'h0, e, 3'd1, 3, 1'b1, 1'b0);
      chk("t1_addr_b0", 512'(got_addr[0]), 512'({32'h10C, 32'h108, 32'h104, 32'h100}));
      chk("t1_en_b0", 512'(got_en[0]), 512'(4'b1111));

      // Strided bytes, four beats.
      dmode = 1;
      e = '0; e[127:0] = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
      run_cmd(VLSU_VLSE8, 3'b000, 7'd16, 32'h0, 32'd16, e, 3'd1, 9, 1'b1, 1'b0);
      chk("t2_addr_b0", 512'(got_addr[0]), 512'({32'd48, 32'd32, 32'd16, 32'd0}));
      chk("t2_addr_b3", 512'(got_addr[3]), 512'({32'd240, 32'd224, 32'd208, 32'd192}));
      chk("t2_beats", 512'(mb), 512'd4);

      // vl = 0: straight to writeback, image cleared.
      e = '0;
      run_cmd(VLSU_VLE8, 3'b000, 7'd0, 32'h40, 32'h0, e, 3'd1, 1, 1'b0, 1'b0);

      // Two-register group, partial second beat.
      e = '0;
      e[159:0] = {32'hEEDDA004, 32'hEEDDA003, 32'hEEDDA002, 32'hEEDDA001, 32'hEEDDA000};
      run_cmd(VLSU_VLE32, 3'b001, 7'd5, 32'h2000, 32'h0, e, 3'd2, 5, 1'b1, 1'b0);
      chk("t3_en_b0", 512'(got_en[0]), 512'(4'b1111));
      chk("t3_en_b1", 512'(got_en[1]), 512'(4'b0001));
      chk("t3_addr_b1", 512'(got_addr[1]), 512'({32'h201C, 32'h2018, 32'h2014, 32'h2010}));

      // Reserved LMUL, vl clamped to one register of halfwords.
      e = '0; e[127:0] = 128'hA007A006_A005A004_A003A002_A001A000;
      run_cmd(VLSU_VLE16, 3'b011, 7'd20, 32'h3000, 32'h0, e, 3'd1, 5, 1'b1, 1'b0);
      chk("t4_beats", 512'(mb), 512'd2);
      chk("t4_addr_b1", 512'(got_addr[1]), 512'({32'h300E, 32'h300C, 32'h300A, 32'h3008}));
      chk("t4_en_b1", 512'(got_en[1]), 512'(4'b1111));

      // Grant stall + late rvalid, address wrap, start while busy ignored.
      gnt_delay = 3; rv_delay = 2;
      e = '0; e[127:0] = {32'hEEDDA003, 32'hEEDDA002, 32'hEEDDA001, 32'hEEDDA000};
      run_cmd(VLSU_VLE32, 3'b000, 7'd4, 32'hFFFF_FFF8, 32'h0, e, 3'd1, 8, 1'b1, 1'b1);
      chk("t5_stall_cycles", 512'(stall_seen), 512'd3);
      chk("t5_addr_stable", 512'(stall_bad), 512'd0);
      chk("t5_addr_wrap", 512'(got_addr[0]), 512'({32'h4, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFF8}));
      gnt_delay = 0; rv_delay = 0;

      // Reset in WAIT of beat 2 of a 16-beat load.
      @(negedge clk);
      vlsu_op = VLSU_VLE8; lmul = 3'b010; vl = 7'd64; base_addr = 32'h5000; stride = '0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!(mb == 3 && !mem_req) && n < 100) begin
         @(posedge clk);
         #2;
         n++;
      end
      chk("t6_reach_beat2", 512'(mb), 512'd3);
      nrst = 1'b0;
      #1;
      chk("t6_busy", 512'(busy), 512'd0);
      chk("t6_mem_req", 512'(mem_req), 512'd0);
      chk("t6_mem_addr", 512'(mem_addr), 512'd0);
      chk("t6_lane_en", 512'(mem_lane_en), 512'd0);
      chk("t6_wb_valid", 512'(wb_valid), 512'd0);
      chk("t6_wb_data", wb_data, 512'd0);
      chk("t6_wb_nreg", 512'(wb_nreg), 512'd0);
      repeat (2) @(negedge clk);
      nrst = 1'b1;
      repeat (8) @(negedge clk);
      chk("t6_idle_after_rst", 512'(busy), 512'd0);

      dmode = 0;
      e = '0; e[127:0] = 128'h00000044_00000033_00000022_00000011;
      run_cmd(VLSU_VLE32, 3'b000, 7'd4, 32'h100, 32'h0, e, 3'd1, 3, 1'b1, 1'b0);
      chk("t7_addr_b0", 512'(got_addr[0]), 512'({32'h10C, 32'h108, 32'h104, 32'h100}));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
